// File: rtl/instr_encoder.sv
// instr_encoder: packs field-level instruction requests into RV32I words
// (lw, sw, R-type, beq, I-type ALU, jal) and streams them with byte
// addresses through a one-stage registered valid/ready pipeline.
module instr_encoder #(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_f7b5,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic [ADDR_W-1:0] out_count,
    output logic              err
);

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_REG    = 7'b0110011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

    localparam logic [2:0] CLS_LW   = 3'd0;
    localparam logic [2:0] CLS_SW   = 3'd1;
    localparam logic [2:0] CLS_R    = 3'd2;
    localparam logic [2:0] CLS_BEQ  = 3'd3;
    localparam logic [2:0] CLS_IALU = 3'd4;
    localparam logic [2:0] CLS_JAL  = 3'd5;

    logic              valid_q;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] count_q;
    logic              err_q;

    logic [31:0]       instr_d;
    logic              imm_bad_d;
    logic              accept;
    logic              out_fire;

    // Immediate range predicates: the upper bits must be a pure sign
    // extension of the field that actually gets encoded.
    logic fits_12s;
    logic fits_13s;
    logic fits_21s;
    logic fits_shamt;
    logic is_shift;

    assign fits_12s   = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    assign fits_13s   = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
    assign fits_21s   = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);
    assign fits_shamt = (in_imm[31:5] == '0);
    assign is_shift   = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

    // Handshakes: the output register frees up when it is empty or draining.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_fire = valid_q && out_ready;

    // Encode the request; out-of-range immediates are truncated and flagged.
    always_comb begin
        instr_d   = NOP_WORD;
        imm_bad_d = 1'b0;
        case (in_class)
            CLS_LW: begin
                instr_d   = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LOAD};
                imm_bad_d = !fits_12s;
            end
            CLS_SW: begin
                instr_d   = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_STORE};
                imm_bad_d = !fits_12s;
            end
            CLS_R: begin
                instr_d   = {1'b0, in_f7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_REG};
            end
            CLS_BEQ: begin
                instr_d   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                             in_imm[4:1], in_imm[11], OP_BRANCH};
                imm_bad_d = !fits_13s || in_imm[0];
            end
            CLS_IALU: begin
                if (is_shift) begin
                    instr_d   = {1'b0, in_f7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_IMM};
                    imm_bad_d = !fits_shamt;
                end else begin
                    instr_d   = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IMM};
                    imm_bad_d = !fits_12s;
                end
            end
            CLS_JAL: begin
                instr_d   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
                imm_bad_d = !fits_21s || in_imm[0];
            end
            default: begin
                // Illegal class: emit a harmless NOP and flag it.
                instr_d   = NOP_WORD;
                imm_bad_d = 1'b1;
            end
        endcase
    end

    // Output stage, word counter and sticky error; clear acts like reset and
    // wins over any coincident handshake.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (out_fire) begin
                count_q <= count_q + ADDR_W'(1);
            end
            if (accept) begin
                valid_q <= 1'b1;
                instr_q <= instr_d;
                if (imm_bad_d) begin
                    err_q <= 1'b1;
                end
            end else if (out_fire) begin
                valid_q <= 1'b0;
            end
        end
    end

    // The presented word is always the next one to be counted, so its
    // address follows directly from the count.
    assign out_addr  = BASE_ADDR + (count_q << 2);
    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_count = count_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed encodings, address and
// count tracking, back-pressure, error flag and clear/reset behaviour.
module tb_instr_encoder;

    localparam int unsigned       ADDR_W = 32;
    localparam logic [31:0]       BASE   = 32'h0000_1000;

    logic              clk;
    logic              reset;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_class;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic              in_f7b5;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic [ADDR_W-1:0] out_count;
    logic              err;

    int n_cmp = 0;
    int n_bad = 0;

    instr_encoder #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_f7b5   (in_f7b5),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .out_count (out_count),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end else begin
            $display("ok   %s: %08h", tag, obs);
        end
    endtask

    task automatic set_req(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                           input logic [31:0] imm);
        in_class  = cls;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_f7b5   = f7;
        in_imm    = imm;
    endtask

    // Present one request for one clock, then sample just after the edge.
    task automatic send(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                        input logic [31:0] imm);
        set_req(cls, rd, rs1, rs2, f3, f7, imm);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_req(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
        tick; tick;

        // Reset state
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_count", out_count, 32'd0);
        chk("rst_err",   {31'd0, err}, 32'd0);
        chk("rst_addr",  out_addr, BASE);
        reset     = 1'b0;
        out_ready = 1'b1;
        tick;

        // lw x5,8(x2)
        send(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 32'd8);
        chk("lw_valid", {31'd0, out_valid}, 32'd1);
        chk("lw_instr", out_instr, 32'h00812283);
        chk("lw_addr",  out_addr, BASE);
        chk("lw_err",   {31'd0, err}, 32'd0);

        // clear drops the pending word and restarts numbering
        clear = 1'b1;
        tick;
        clear = 1'b0;
        chk("clr_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_count", out_count, 32'd0);

        // sw x6,-4(x2) then sub x1,x2,x3 back-to-back
        send(3'd1, 5'd0, 5'd2, 5'd6, 3'd0, 1'b0, 32'hFFFF_FFFC);
        chk("sw_instr", out_instr, 32'hFE612E23);
        chk("sw_addr",  out_addr, BASE);
        send(3'd2, 5'd1, 5'd2, 5'd3, 3'd0, 1'b1, 32'd0);
        chk("sub_instr", out_instr, 32'h403100B3);
        chk("sub_addr",  out_addr, BASE + 32'd4);
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFF8);
        chk("beq_instr", out_instr, 32'hFE208CE3);
        chk("beq_addr",  out_addr, BASE + 32'd8);
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048);
        chk("jal_instr", out_instr, 32'h001000EF);
        chk("jal_addr",  out_addr, BASE + 32'hC);
        send(3'd4, 5'd4, 5'd4, 5'd0, 3'b101, 1'b1, 32'd3);
        chk("srai_instr", out_instr, 32'h40325213);
        chk("srai_addr",  out_addr, BASE + 32'h10);
        chk("srai_err",   {31'd0, err}, 32'd0);
        chk("srai_count", out_count, 32'd4);

        // Back-pressure: srai held, new request must not be taken
        out_ready = 1'b0;
        set_req(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 32'd8);
        in_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d_ready", i), {31'd0, in_ready}, 32'd0);
            tick;
            chk($sformatf("stall%0d_instr", i), out_instr, 32'h40325213);
            chk($sformatf("stall%0d_addr", i),  out_addr, BASE + 32'h10);
            chk($sformatf("stall%0d_count", i), out_count, 32'd4);
        end

        // Release: srai drains and the waiting lw is accepted the same edge
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("rel_instr", out_instr, 32'h00812283);
        chk("rel_addr",  out_addr, BASE + 32'h14);
        chk("rel_count", out_count, 32'd5);
        tick;
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_count", out_count, 32'd6);

        // Misaligned beq offset: flagged but still emitted
        send(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3);
        chk("beq3_instr", out_instr, 32'h00000163);
        chk("beq3_err",   {31'd0, err}, 32'd1);
        chk("beq3_addr",  out_addr, BASE + 32'h18);
        // Illegal class
        send(3'd7, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 32'd0);
        chk("ill_instr", out_instr, 32'h00000013);
        chk("ill_err",   {31'd0, err}, 32'd1);
        // clear wins over the coincident output handshake
        clear = 1'b1;
        tick;
        clear = 1'b0;
        chk("clr2_err",   {31'd0, err}, 32'd0);
        chk("clr2_addr",  out_addr, BASE);
        chk("clr2_count", out_count, 32'd0);
        chk("clr2_valid", {31'd0, out_valid}, 32'd0);

        // addi x1,x0,2048 is out of range: truncated and flagged
        send(3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2048);
        chk("addi_instr", out_instr, 32'h80000093);
        chk("addi_err",   {31'd0, err}, 32'd1);
        clear = 1'b1;
        tick;
        clear = 1'b0;

        // Stream of four lw words at full rate
        for (int i = 0; i < 4; i++) begin
            set_req(3'd0, 5'(i + 1), 5'd2, 5'd0, 3'd0, 1'b0, 32'd8);
            in_valid = 1'b1;
            tick;
            chk($sformatf("strm%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("strm%0d_instr", i), out_instr, 32'h00812003 | (32'(i + 1) << 7));
            chk($sformatf("strm%0d_addr", i),  out_addr, BASE + 32'(4 * i));
        end
        // Reset mid-stream with a request still offered
        reset = 1'b1;
        tick;
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_count", out_count, 32'd0);
        chk("mid_rst_addr",  out_addr, BASE);
        tick;
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
